cpu6_memresp: RTL
=================

CPU6_MEMRESP -- requirements
Module: cpu6_memresp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits of the RAM (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter RESET_INSTR, default 32'h00000013, value driven on instr during and after reset.
REQ-003 SHALL have one clock, clk, and reset asynchronous active-low: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-005 pcfetchaddr  input  32  byte address of the next instruction fetch.
REQ-006 instr  output  32  fetched instruction, registered.
REQ-007 memwriteM  input  1  data write strobe, sampled at the rising edge.
REQ-008 dataaddr  input  32  data byte address.
REQ-009 writedata  input  32  store data.
REQ-010 readdata  output  32  load data, combinational.
REQ-011 ioout  output  32  OUT register value.
REQ-012 halt  output  1  sticky halt flag.
REQ-013 tohost  output  32  value written at halt.

Function
REQ-014 Word index SHALL be addr[ADDR_W+1:2]; RAM range is addr[31:ADDR_W+2]==0; MMIO range is addr[31:28]==4'hF; all other addresses are unmapped.
REQ-015 RAM SHALL be unified: the fetch port and the data port share one array.
REQ-016 Fetch: instr SHALL update at each rising edge to RAM[word index of pcfetchaddr] (latency 1 cycle); an unmapped or MMIO pcfetchaddr SHALL yield RESET_INSTR.
REQ-017 Fetch-write collision: same edge, same word, memwriteM=1 -> instr SHALL take writedata (write-first).
REQ-018 Data write SHALL occur at the rising edge when memwriteM=1, addr[1:0]==0, and the address is mapped; full 32-bit word only.
REQ-019 Data read: readdata SHALL be combinational from dataaddr: RAM word, MMIO register, or 0 for unmapped/unused MMIO offsets.
REQ-020 MMIO 0xF0000000 OUT SHALL be read/write; ioout mirrors it.
REQ-021 MMIO 0xF0000004 CYCLE SHALL be read-only; increments every cycle out of reset; wraps 32'hFFFFFFFF -> 0; writes ignored.
REQ-022 MMIO 0xF0000008 STATUS SHALL have bit0 = misaligned-write sticky and bit1 = unmapped-write sticky; writing 1 to a bit clears it; other bits read 0.
REQ-023 MMIO 0xF000000C TOHOST: a write SHALL load tohost and set halt=1; halt stays 1 until reset; later writes still update tohost.
REQ-024 memwriteM=1 with addr[1:0]!=0 SHALL be dropped and SHALL set STATUS bit0 at that edge.
REQ-025 memwriteM=1 to an unmapped, aligned address SHALL be dropped and SHALL set STATUS bit1.
REQ-026 A write to an unused MMIO offset (0xF0000010 and above in MMIO space) SHALL be dropped silently, with no STATUS change.
REQ-027 Reads SHALL have no side effects and set no error bits.
REQ-028 Write followed by read of the same word in the next cycle SHALL return the new data.

Reset
REQ-029 While reset=0: instr=RESET_INSTR, ioout=0, CYCLE=0, STATUS=0, halt=0, tohost=0; takes effect immediately, without waiting for a clock edge.
REQ-030 RAM contents SHALL NOT be altered by reset.
REQ-031 Reset asserted mid-operation SHALL suppress any write on the same edge; CYCLE counts from 0 starting at the first edge after deassertion.

Verification
REQ-032 Preload RAM[4]=32'hDEADBEEF; pcfetchaddr=0x10 -> instr=32'hDEADBEEF one edge later; RESET_INSTR before that edge.
REQ-033 memwriteM=1, dataaddr=0x20, writedata=0x12345678, with pcfetchaddr=0x20 on the same edge -> instr=0x12345678; next cycle readdata at 0x20 = 0x12345678.
REQ-034 Write 0x22 to 0x22 (misaligned) -> RAM unchanged, STATUS=1; write 1 to 0xF0000008 -> STATUS=0; write to 0x00100000 (ADDR_W=10) -> STATUS=2.
REQ-035 Reset deasserted, 5 edges -> CYCLE reads 5; force CYCLE=32'hFFFFFFFF -> reads 0 after the next edge.
REQ-036 Write 0xA5 to 0xF0000000 -> ioout=0xA5; write 7 to 0xF000000C -> halt=1, tohost=7; assert reset mid-cycle -> halt=0, ioout=0 immediately, RAM[8] still holds its prior value.

Source files
------------

// File: rtl/cpu6_memresp.sv
// Unified instruction/data RAM with a registered fetch port, a combinational data
// read port and a small MMIO block (OUT, CYCLE, STATUS, TOHOST).
module cpu6_memresp #(
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcfetchaddr,
   output logic [31:0] instr,
   input  logic        memwriteM,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [31:0] ioout,
   output logic        halt,
   output logic [31:0] tohost
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       r_ram [DEPTH];
   logic [31:0]       r_out;
   logic [31:0]       r_cycle;
   logic [1:0]        r_status;
   logic [31:0]       r_tohost;
   logic              r_halt;

   logic              w_run;
   logic              w_d_ram;
   logic              w_d_mmio;
   logic              w_d_align;
   logic [ADDR_W-1:0] w_d_idx;
   logic [25:0]       w_d_off;
   logic              w_f_ram;
   logic [ADDR_W-1:0] w_f_idx;
   logic              w_ram_we;
   logic              w_unused;

   assign w_run     = reset;
   assign w_d_ram   = (dataaddr[31:ADDR_W+2] == '0);
   assign w_d_mmio  = (dataaddr[31:28] == 4'hF);
   assign w_d_align = (dataaddr[1:0] == 2'b00);
   assign w_d_idx   = dataaddr[ADDR_W+1:2];
   assign w_d_off   = dataaddr[27:2];
   assign w_f_ram   = (pcfetchaddr[31:ADDR_W+2] == '0);
   assign w_f_idx   = pcfetchaddr[ADDR_W+1:2];
   assign w_unused  = ^pcfetchaddr[1:0];

   // RAM is never cleared; a write landing on an edge while reset is held is dropped.
   assign w_ram_we  = memwriteM & w_d_align & w_d_ram & w_run;

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_d_idx] <= writedata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr <= RESET_INSTR;
      end else if (!w_f_ram) begin
         instr <= RESET_INSTR;
      end else if (w_ram_we && (w_f_idx == w_d_idx)) begin
         instr <= writedata;
      end else begin
         instr <= r_ram[w_f_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out    <= '0;
         r_cycle  <= '0;
         r_status <= '0;
         r_tohost <= '0;
         r_halt   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (memwriteM) begin
            if (!w_d_align) begin
               r_status[0] <= 1'b1;
            end else if (w_d_ram) begin
               r_status <= r_status;
            end else if (w_d_mmio) begin
               case (w_d_off)
                  26'd0:   r_out <= writedata;
                  26'd2:   r_status <= r_status & ~writedata[1:0];
                  26'd3: begin
                     r_tohost <= writedata;
                     r_halt   <= 1'b1;
                  end
                  default: r_status <= r_status;
               endcase
            end else begin
               r_status[1] <= 1'b1;
            end
         end
      end
   end

   // MMIO reads decode on the word offset; byte-lane bits are ignored as for RAM.
   always_comb begin
      readdata = '0;
      if (w_d_ram) begin
         readdata = r_ram[w_d_idx];
      end else if (w_d_mmio) begin
         case (w_d_off)
            26'd0:   readdata = r_out;
            26'd1:   readdata = r_cycle;
            26'd2:   readdata = {30'd0, r_status};
            26'd3:   readdata = r_tohost;
            default: readdata = '0;
         endcase
      end
   end

   assign ioout  = r_out;
   assign halt   = r_halt;
   assign tohost = r_tohost;

endmodule
